fp_to_int_pipe: RTL and testbench

FP_TO_INT_PIPE -- requirements
Module: fp_to_int_pipe

---
 rtl/fp_to_int_pipe.sv | 162 ++++++++++++++++
 tb/tb_fp_to_int_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_to_int_pipe.sv
// Two-stage converter from {sign, exp, 0.frac x 2^exp} to sign-magnitude or two's-complement integer.
// Define FP2INT_ROUND_EN for round-to-nearest (ties away from zero); default build truncates.
module fp_to_int_pipe #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8,
    parameter int INT_W  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   fp_in,
    input  logic                    twos_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INT_W-1:0]        int_out,
    output logic                    uf,
    output logic                    of,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        uf_cnt,
    output logic [CNT_W-1:0]        of_cnt
);

    localparam int MAG_W = INT_W - 1;

    logic              sign_in;
    logic [EXP_W-1:0]  exp_in;
    logic [FRAC_W-1:0] frac_in;
    assign {sign_in, exp_in, frac_in} = fp_in;

    logic v1_q, v2_q;
    logic en1, en2, fire;

    logic              exp_big;
    int                shift_amt;
    logic [FRAC_W:0]   ext;

    logic              nz1_d, ovf1_d;
    logic [MAG_W-1:0]  mag1_d;
    logic              sign1_q, twos1_q, nz1_q, ovf1_q;
    logic [MAG_W-1:0]  mag1_q;
`ifdef FP2INT_ROUND_EN
    logic              rbit1_d, rbit1_q;
`endif

    logic [INT_W-1:0]  mag2;
    logic [INT_W-1:0]  int_d, int_out_q;
    logic              uf_d, of_d, uf_q, of_q;
    logic [CNT_W-1:0]  uf_cnt_d, of_cnt_d, uf_cnt_q, of_cnt_q;

`ifdef FP2INT_ROUND_EN
    // The first discarded bit set means the remainder is >= one half, so a
    // magnitude increment rounds to nearest with ties away from zero.
    function automatic logic [INT_W-1:0] round_half_away(input logic [MAG_W-1:0] mag,
                                                         input logic rbit);
        return {1'b0, mag} + INT_W'(rbit);
    endfunction
`endif

    function automatic logic [INT_W-1:0] format_out(input logic s, input logic twos,
                                                    input logic ovf,
                                                    input logic [INT_W-1:0] mag);
        if (ovf) begin
            if (twos)
                return s ? {1'b1, {MAG_W{1'b0}}} : {1'b0, {MAG_W{1'b1}}};
            return {s, {MAG_W{1'b1}}};
        end
        if (twos)
            return s ? -mag : mag;
        return {s, mag[MAG_W-1:0]};
    endfunction

    assign en2      = !v2_q || out_ready;
    assign en1      = !v1_q || en2;
    assign in_ready = en1;
    assign fire     = v2_q && out_ready;

    // Stage 1: classification and aligned magnitude; bit 0 of ext is the round bit.
    always_comb begin
        exp_big   = int'(exp_in) > INT_W - 1;
        nz1_d     = |frac_in;
        ovf1_d    = nz1_d && exp_big;
        shift_amt = exp_big ? 0 : FRAC_W - int'(exp_in);
        ext       = {frac_in, 1'b0} >> shift_amt;
        mag1_d    = MAG_W'(ext >> 1);
`ifdef FP2INT_ROUND_EN
        rbit1_d   = ext[0];
`endif
    end

    always_ff @(posedge clk) begin
        if (en1 && in_valid) begin
            sign1_q <= sign_in;
            twos1_q <= twos_mode;
            nz1_q   <= nz1_d;
            ovf1_q  <= ovf1_d;
            mag1_q  <= mag1_d;
`ifdef FP2INT_ROUND_EN
            rbit1_q <= rbit1_d;
`endif
        end
    end

    // Stage 2: rounding, flags and output formatting.
    always_comb begin
`ifdef FP2INT_ROUND_EN
        mag2  = round_half_away(mag1_q, rbit1_q);
`else
        mag2  = {1'b0, mag1_q};
`endif
        of_d  = ovf1_q || mag2[INT_W-1];
        uf_d  = nz1_q && !of_d && (mag2 == '0);
        int_d = format_out(sign1_q, twos1_q, of_d, mag2);
    end

    always_comb begin
        uf_cnt_d = uf_cnt_q;
        of_cnt_d = of_cnt_q;
        if (cnt_clr) begin
            uf_cnt_d = '0;
            of_cnt_d = '0;
        end else begin
            if (fire && uf_q && !(&uf_cnt_q))
                uf_cnt_d = uf_cnt_q + CNT_W'(1);
            if (fire && of_q && !(&of_cnt_q))
                of_cnt_d = of_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            int_out_q <= '0;
            uf_q      <= 1'b0;
            of_q      <= 1'b0;
            uf_cnt_q  <= '0;
            of_cnt_q  <= '0;
        end else begin
            if (en1)
                v1_q <= in_valid;
            if (en2)
                v2_q <= v1_q;
            if (en2 && v1_q) begin
                int_out_q <= int_d;
                uf_q      <= uf_d;
                of_q      <= of_d;
            end
            uf_cnt_q <= uf_cnt_d;
            of_cnt_q <= of_cnt_d;
        end
    end

    assign out_valid = v2_q;
    assign int_out   = int_out_q;
    assign uf        = uf_q;
    assign of        = of_q;
    assign uf_cnt    = uf_cnt_q;
    assign of_cnt    = of_cnt_q;

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Scoreboard bench for fp_to_int_pipe; expected words come from an arithmetic reference model.
module tb_fp_to_int_pipe;

    localparam int EXP_W  = 4;
    localparam int FRAC_W = 8;
    localparam int INT_W  = 8;
    localparam int CNT_W  = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] fp_in = '0;
    logic        twos_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  int_out;
    logic        uf, of;
    logic        cnt_clr = 1'b0;
    logic [1:0]  uf_cnt, of_cnt;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    logic [9:0] sbq[$];
    logic [9:0] exp_w;
    logic [9:0] held = '0;
    logic       stall_prev = 1'b0;

    fp_to_int_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .INT_W(INT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .fp_in(fp_in), .twos_mode(twos_mode), .out_valid(out_valid), .out_ready(out_ready),
        .int_out(int_out), .uf(uf), .of(of), .cnt_clr(cnt_clr),
        .uf_cnt(uf_cnt), .of_cnt(of_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference: value = frac * 2^exp / 2^8, returned as {of, uf, int}.
    function automatic logic [9:0] model(input logic [12:0] fp, input logic tm);
        logic       s, o, u;
        int         e, f, num, m;
        logic [7:0] r;
        s = fp[12];
        e = int'(fp[11:8]);
        f = int'(fp[7:0]);
        o = 1'b0;
        u = 1'b0;
        m = 0;
        if (f == 0) begin
            m = 0;
        end else if (e > 7) begin
            o = 1'b1;
        end else begin
            num = f << e;
            m   = num >> 8;
`ifdef FP2INT_ROUND_EN
            if (((num >> 7) % 2) == 1)
                m = m + 1;
`endif
            if (m >= 128)
                o = 1'b1;
            else if (m == 0)
                u = 1'b1;
        end
        if (o)
            r = tm ? (s ? 8'h80 : 8'h7F) : {s, 7'h7F};
        else if (tm)
            r = s ? 8'(-m) : 8'(m);
        else
            r = {s, 7'(m)};
        return {o, u, r};
    endfunction

    always @(negedge clk) begin
        if (reset_n && in_valid && in_ready)
            sbq.push_back(model(fp_in, twos_mode));
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got %h with empty scoreboard", {of, uf, int_out});
            end else begin
                exp_w = sbq.pop_front();
                pops++;
                if ({of, uf, int_out} !== exp_w) begin
                    errors++;
                    $display("FAIL scoreboard got of/uf/int %h required %h", {of, uf, int_out}, exp_w);
                end
            end
        end
        if (reset_n && stall_prev && out_valid) begin
            checks++;
            if ({of, uf, int_out} !== held) begin
                errors++;
                $display("FAIL stall_hold got %h required %h", {of, uf, int_out}, held);
            end
        end
        stall_prev = reset_n && out_valid && !out_ready;
        held       = {of, uf, int_out};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [12:0] fp, input logic tm);
        int k;
        in_valid  = 1'b1;
        fp_in     = fp;
        twos_mode = tm;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready got 0 required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        k = 0;
        while ((sbq.size() != 0 || out_valid) && k < 100) begin
            step();
            k++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d required 0", sbq.size());
        end
    endtask

    task automatic wait_out_valid();
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout got 0 required 1");
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, uf, of, in_ready, int_out, uf_cnt, of_cnt} !== {4'b0001, 8'h00, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL reset_state got v/uf/of/rdy %b int %h cnt %h/%h required 0001 00 0/0",
                     {out_valid, uf, of, in_ready}, int_out, uf_cnt, of_cnt);
        end
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_latency();
        in_valid  = 1'b1;
        fp_in     = 13'b0_0101_10110000;
        twos_mode = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL first_accept in_ready got %b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_c1 out_valid got %b required 0", out_valid);
        end
        step();
        checks++;
        if ({out_valid, of, uf, int_out} !== {3'b100, 8'h16}) begin
            errors++;
            $display("FAIL latency_c2 got v/of/uf %b int %h required 100 16",
                     {out_valid, of, uf}, int_out);
        end
        drain();
    endtask

    task automatic test_vectors();
        logic [13:0] vec[15];
        vec = '{
            {13'b0_0101_10110000, 1'b1}, {13'b1_0101_10110000, 1'b1}, {13'b1_0101_10110000, 1'b0},
            {13'b1_1000_10000000, 1'b0}, {13'b1_1000_10000000, 1'b1}, {13'b0_1111_00000000, 1'b0},
            {13'b1_1111_00000000, 1'b0}, {13'b1_1111_00000000, 1'b1}, {13'b0_0000_01000000, 1'b0},
            {13'b0_0000_10000000, 1'b0}, {13'b0_0111_11111111, 1'b0}, {13'b0_0101_10110100, 1'b0},
            {13'b1_0111_11111111, 1'b1}, {13'b0_0111_11111111, 1'b1}, {13'b1_0101_10110100, 1'b1}
        };
        out_ready = 1'b1;
        foreach (vec[i])
            send(vec[i][13:1], vec[i][0]);
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 80; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            fp_in     = 13'($urandom);
            twos_mode = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_stall();
        int idx, base, c, low_seen;
        idx = 0;
        base = pops;
        low_seen = 0;
        c = 0;
        while ((idx < 5 || sbq.size() != 0 || out_valid) && c < 40) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = idx < 5;
            fp_in     = {1'b0, 4'(idx + 3), 8'(8'h9D + idx * 17)};
            twos_mode = idx[0];
            @(negedge clk);
            if (!in_ready)
                low_seen++;
            if (in_valid && in_ready)
                idx++;
            step();
            c++;
        end
        in_valid = 1'b0;
        checks++;
        if (low_seen == 0) begin
            errors++;
            $display("FAIL stall_backpressure in_ready low cycles got 0 required >0");
        end
        checks++;
        if (pops - base != 5) begin
            errors++;
            $display("FAIL stall_delivered got %0d required 5", pops - base);
        end
        drain();
    endtask

    task automatic test_reset_inflight();
        int seen;
        out_ready = 1'b0;
        send({1'b0, 4'd6, 8'hC3}, 1'b0);
        send({1'b1, 4'd4, 8'hF1}, 1'b1);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, int_out} !== 9'h000) begin
            errors++;
            $display("FAIL reset_inflight got v %b int %h required 0 00", out_valid, int_out);
        end
        sbq.delete();
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid)
                seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL stale_output got %0d valid cycles required 0", seen);
        end
        send({1'b0, 4'd3, 8'hA0}, 1'b0);
        drain();
    endtask

    task automatic test_counters();
        logic [1:0] want;
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checks++;
        if ({uf_cnt, of_cnt} !== 4'b0000) begin
            errors++;
            $display("FAIL cnt_clear got %h/%h required 0/0", uf_cnt, of_cnt);
        end
        for (int k = 1; k <= 5; k++) begin
            send({1'b0, 4'hF, 8'hFF}, 1'b0);
            wait_out_valid();
            step();
            want = (k > 3) ? 2'd3 : 2'(k);
            checks++;
            if (of_cnt !== want) begin
                errors++;
                $display("FAIL of_cnt_%0d got %0d required %0d", k, of_cnt, want);
            end
        end
        send({1'b1, 4'h9, 8'h01}, 1'b1);
        wait_out_valid();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checks++;
        if (of_cnt !== 2'd0) begin
            errors++;
            $display("FAIL of_cnt_clr_coincident got %0d required 0", of_cnt);
        end
        send({1'b0, 4'h0, 8'h40}, 1'b0);
        wait_out_valid();
        step();
        checks++;
        if ({uf_cnt, of_cnt} !== {2'd1, 2'd0}) begin
            errors++;
            $display("FAIL uf_cnt got %0d/%0d required 1/0", uf_cnt, of_cnt);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_stall();
        test_random();
        test_reset_inflight();
        test_counters();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
